// File: rtl/serial_add_seq_pkg.sv
// Shared definitions for the byte-serial adder sequencer.
// Byte width and FSM state encodings live here.
package serial_add_seq_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_HOLD = 2'd2
   } state_e;

   function automatic int idx_width(input int nbytes);
      return (nbytes > 1) ? $clog2(nbytes) : 1;
   endfunction

endpackage

// File: rtl/serial_add_seq_if.sv
// Operand/result handshake bundle for serial_add_seq.
// op_sub exists only when SERADD_SUB_EN is defined.
interface serial_add_seq_if #(
   parameter int NBYTES = 4
);
   localparam int W = 8 * NBYTES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic         ci_in;
`ifdef SERADD_SUB_EN
   logic         op_sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum_out;
   logic         co_out;
   logic         ovf_out;

   modport slave (
      input  in_valid,
      output in_ready,
      input  a_in,
      input  b_in,
      input  ci_in,
`ifdef SERADD_SUB_EN
      input  op_sub,
`endif
      output out_valid,
      input  out_ready,
      output sum_out,
      output co_out,
      output ovf_out
   );

   modport master (
      output in_valid,
      input  in_ready,
      output a_in,
      output b_in,
      output ci_in,
`ifdef SERADD_SUB_EN
      output op_sub,
`endif
      input  out_valid,
      output out_ready,
      input  sum_out,
      input  co_out,
      input  ovf_out
   );

endinterface

// File: rtl/serial_add_seq_add8_slice.sv
// Combinational 8-bit add slice: y = a + b + ci.
// c7 is the carry into bit 7, used for signed overflow.
import serial_add_seq_pkg::*;

module add8_slice (
   input  logic [BYTE_W-1:0] a_i,
   input  logic [BYTE_W-1:0] b_i,
   input  logic              ci_i,
   output logic [BYTE_W-1:0] y_o,
   output logic              co_o,
   output logic              c7_o
);

   logic [BYTE_W-1:0] lo;
   logic [1:0]        hi;

   // Split at bit 7 so the carry into the sign bit is visible.
   assign lo = {1'b0, a_i[BYTE_W-2:0]}
             + {1'b0, b_i[BYTE_W-2:0]}
             + {{(BYTE_W-1){1'b0}}, ci_i};

   assign hi = {1'b0, a_i[BYTE_W-1]}
             + {1'b0, b_i[BYTE_W-1]}
             + {1'b0, lo[BYTE_W-1]};

   assign y_o  = {hi[0], lo[BYTE_W-2:0]};
   assign co_o = hi[1];
   assign c7_o = lo[BYTE_W-1];

endmodule

// File: rtl/serial_add_seq.sv
// Byte-serial multi-precision adder sequencer, LSB byte first.
// Define SERADD_SUB_EN to add the op_sub (A-B) mode.
import serial_add_seq_pkg::*;

module serial_add_seq #(
   parameter int NBYTES = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   serial_add_seq_if.slave      bus
);

   localparam int W     = BYTE_W * NBYTES;
   localparam int IDX_W = idx_width(NBYTES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             co_q, co_d;
   logic             ovf_q, ovf_d;
   logic             valid_q, valid_d;

   logic [BYTE_W-1:0] sl_a;
   logic [BYTE_W-1:0] sl_b;
   logic [BYTE_W-1:0] sl_y;
   logic              sl_co;
   logic              sl_c7;

   assign sl_a = a_q[idx_q*BYTE_W +: BYTE_W];
   assign sl_b = b_q[idx_q*BYTE_W +: BYTE_W];

   add8_slice u_slice (
      .a_i  (sl_a),
      .b_i  (sl_b),
      .ci_i (carry_q),
      .y_o  (sl_y),
      .co_o (sl_co),
      .c7_o (sl_c7)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         co_q    <= 1'b0;
         ovf_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         co_q    <= co_d;
         ovf_q   <= ovf_d;
         valid_q <= valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      co_d    = co_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d = bus.a_in;
`ifdef SERADD_SUB_EN
               // Subtract as A + ~B + 1; ci_in is ignored.
               b_d     = bus.op_sub ? ~bus.b_in : bus.b_in;
               carry_d = bus.op_sub ? 1'b1 : bus.ci_in;
`else
               b_d     = bus.b_in;
               carry_d = bus.ci_in;
`endif
               idx_d   = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            sum_d[idx_q*BYTE_W +: BYTE_W] = sl_y;
            carry_d = sl_co;
            if (idx_q == IDX_LAST) begin
               idx_d   = '0;
               co_d    = sl_co;
               ovf_d   = sl_c7 ^ sl_co;
               valid_d = 1'b1;
               state_d = S_HOLD;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end

         S_HOLD: begin
            if (bus.out_ready) begin
               valid_d = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = valid_q;
   assign bus.sum_out   = sum_q;
   assign bus.co_out    = co_q;
   assign bus.ovf_out   = ovf_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Randomized self-checking bench for serial_add_seq (NBYTES=4).
// Build with SERADD_SUB_EN to exercise the subtract mode.
module tb_serial_add_seq;

   localparam int NB = 4;

   logic clk;
   logic reset_n;
   int   n_chk = 0;
   int   n_err = 0;

   serial_add_seq_if #(.NBYTES(NB)) bus ();

   serial_add_seq #(.NBYTES(NB)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_op(input logic [31:0] a, input logic [31:0] b,
                           input logic ci, input logic sb);
      bus.in_valid = 1'b1;
      bus.a_in     = a;
      bus.b_in     = b;
      bus.ci_in    = ci;
`ifdef SERADD_SUB_EN
      bus.op_sub   = sb;
`else
      if (sb) $display("note: subtract requested without SERADD_SUB_EN");
`endif
   endtask

   // Full transaction against an arithmetic model of A+B+ci or A-B.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic sb, input int stall, input bit poke);
      logic [31:0] be;
      logic        cin;
      logic [32:0] ex;
      logic        eovf;
      int          lat;
      be   = sb ? ~b : b;
      cin  = sb ? 1'b1 : ci;
      ex   = {1'b0, a} + {1'b0, be} + {32'd0, cin};
      eovf = (a[31] == be[31]) && (ex[31] != a[31]);

      @(negedge clk);
      check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
      drive_op(a, b, ci, sb);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.a_in     = $urandom;
      bus.b_in     = $urandom;
      check({tag, ".busy"}, 64'(bus.in_ready), 64'd0);

      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, ".latency"}, 64'(lat), 64'(NB));
      check({tag, ".sum"}, 64'(bus.sum_out), 64'(ex[31:0]));
      check({tag, ".co"}, 64'(bus.co_out), 64'(ex[32]));
      check({tag, ".ovf"}, 64'(bus.ovf_out), 64'(eovf));

      for (int i = 0; i < stall; i++) begin
         if (poke) drive_op($urandom, $urandom, 1'b1, 1'b0);
         @(posedge clk);
         #1;
         check({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
         check({tag, ".hold_rdy"}, 64'(bus.in_ready), 64'd0);
         check({tag, ".hold_out"}, {31'd0, bus.ovf_out, bus.co_out, bus.sum_out},
               {31'd0, eovf, ex[32], ex[31:0]});
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({tag, ".drop_valid"}, 64'(bus.out_valid), 64'd0);
      check({tag, ".idle_rdy"}, 64'(bus.in_ready), 64'd1);
      check({tag, ".kept"}, {31'd0, bus.ovf_out, bus.co_out, bus.sum_out},
            {31'd0, eovf, ex[32], ex[31:0]});
   endtask

   initial begin
      int pulses;
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.a_in      = '0;
      bus.b_in      = '0;
      bus.ci_in     = 1'b0;
      bus.out_ready = 1'b0;
`ifdef SERADD_SUB_EN
      bus.op_sub    = 1'b0;
`endif
      #12;
      check("rst.valid", 64'(bus.out_valid), 64'd0);
      check("rst.sum", 64'(bus.sum_out), 64'd0);
      check("rst.co", 64'(bus.co_out), 64'd0);
      check("rst.ovf", 64'(bus.ovf_out), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst.in_ready", 64'(bus.in_ready), 64'd1);

      run_op("t1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
      run_op("t2", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 0, 1'b0);

      // Abort mid-RUN at idx=2; the partial sum must vanish.
      @(negedge clk);
      drive_op(32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("t5.valid", 64'(bus.out_valid), 64'd0);
      check("t5.sum", 64'(bus.sum_out), 64'd0);
      check("t5.co", 64'(bus.co_out), 64'd0);
      check("t5.ovf", 64'(bus.ovf_out), 64'd0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("t5.in_ready", 64'(bus.in_ready), 64'd1);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.out_valid) pulses++;
      end
      check("t5.no_pulse", 64'(pulses), 64'd0);
      run_op("t5.next", 32'd3, 32'd4, 1'b0, 1'b0, 0, 1'b0);

      run_op("t3", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, 1'b0);
      run_op("t4", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 5, 1'b1);

`ifdef SERADD_SUB_EN
      run_op("t6a", 32'd5, 32'd7, 1'b1, 1'b1, 0, 1'b0);
      run_op("t6b", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 0, 1'b0);
`endif

      for (int k = 0; k < 40; k++) begin
         logic sb;
`ifdef SERADD_SUB_EN
         sb = 1'($urandom_range(0, 1));
`else
         sb = 1'b0;
`endif
         run_op("rnd", $urandom, $urandom, 1'($urandom_range(0, 1)), sb,
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
